// File: rtl/clock_div_pkg.sv
// Shared types and constants for the divided-clock monitor.
package clock_div_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam int DEF_SIZE  = 3;
    localparam int DEF_CNT_W = 8;

    // Allowed deviation of the measured period from expected_n, in clk cycles
    localparam int TOL = 1;

endpackage

// File: rtl/clk_edge_sync.sv
// Brings an asynchronous clock-like signal into the clk domain and produces
// a registered level plus a one-cycle pulse for each rising edge. The pulse
// appears 3 clk cycles after the input rises, and 'level' is aligned with it
// so the cycle carrying the pulse also reads level=1.
module clk_edge_sync (
    input  logic clk,
    input  logic resetb,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic sync1;
    logic sync2;

    // Two-stage synchronizer, delayed copy for edge detect, registered pulse
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            level <= sync2;
            rise  <= sync2 & ~level;
        end
    end

endmodule

// File: rtl/clock_div_monitor.sv
// Measures period and high time of a divided clock in clk cycles, compares
// the period against the expected divide ratio and flags a stalled clock.
module clock_div_monitor
    import clock_div_pkg::*;
#(
    parameter int SIZE    = DEF_SIZE,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             mon_clk,
    input  logic             enable,
    input  logic [SIZE-1:0]  expected_n,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_valid,
    input  logic             meas_ack,
    output logic             mismatch,
    output logic             stuck,
    output logic             bypass
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic             mon_lvl;
    logic             mon_rise;
    state_t           state;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] to_cnt;
    logic             ratio_ok;
    logic [CNT_W:0]   per_ext;
    logic [CNT_W:0]   exp_ext;
    logic [CNT_W:0]   diff;
    logic             off_tol;

    clk_edge_sync u_sync (
        .clk      (clk),
        .resetb   (resetb),
        .async_in (mon_clk),
        .level    (mon_lvl),
        .rise     (mon_rise)
    );

    assign ratio_ok = (expected_n > SIZE'(1));

    // One extra bit so a small period against a large ratio cannot wrap
    assign per_ext = {1'b0, period_cnt};
    assign exp_ext = (CNT_W+1)'(expected_n);
    assign diff    = (per_ext >= exp_ext) ? (per_ext - exp_ext) : (exp_ext - per_ext);
    assign off_tol = (diff > (CNT_W+1)'(TOL));

    // Ratio below 2 cannot be resolved; flag it one cycle later
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) bypass <= 1'b0;
        else         bypass <= ~ratio_ok;
    end

    // Measurement FSM; disable or unusable ratio acts as a synchronous clear
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state       <= IDLE;
            period_cnt  <= '0;
            high_cnt    <= '0;
            to_cnt      <= '0;
            meas_period <= '0;
            meas_high   <= '0;
            meas_valid  <= 1'b0;
            mismatch    <= 1'b0;
            stuck       <= 1'b0;
        end else if (!enable || !ratio_ok) begin
            state       <= IDLE;
            period_cnt  <= '0;
            high_cnt    <= '0;
            to_cnt      <= '0;
            meas_period <= '0;
            meas_high   <= '0;
            meas_valid  <= 1'b0;
            mismatch    <= 1'b0;
            stuck       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= ARM;
                end
                ARM: begin
                    if (mon_rise) begin
                        period_cnt <= CNT_W'(1);
                        high_cnt   <= CNT_W'(1);
                        to_cnt     <= '0;
                        stuck      <= 1'b0;
                        state      <= MEASURE;
                    end else if (to_cnt == TO_LAST) begin
                        stuck  <= 1'b1;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                end
                MEASURE: begin
                    // An edge on the terminal-count cycle wins over the timeout
                    if (mon_rise) begin
                        meas_period <= period_cnt;
                        meas_high   <= high_cnt;
                        mismatch    <= off_tol;
                        meas_valid  <= 1'b1;
                        stuck       <= 1'b0;
                        to_cnt      <= '0;
                        state       <= HOLD;
                    end else if (to_cnt == TO_LAST) begin
                        stuck      <= 1'b1;
                        to_cnt     <= '0;
                        period_cnt <= '0;
                        high_cnt   <= '0;
                        state      <= ARM;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                        if (period_cnt != CNT_MAX) period_cnt <= period_cnt + CNT_W'(1);
                        if (mon_lvl && high_cnt != CNT_MAX) high_cnt <= high_cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    // Results frozen until consumed; edges ignored here
                    if (meas_ack) begin
                        meas_valid <= 1'b0;
                        mismatch   <= 1'b0;
                        period_cnt <= '0;
                        high_cnt   <= '0;
                        to_cnt     <= '0;
                        state      <= ARM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_div_monitor.sv
// Scoreboard bench for clock_div_monitor: a clk-synchronous divider model
// drives mon_clk, expected results are queued as stimulus is set up and
// compared when meas_valid appears.
module tb_clock_div_monitor;

    logic       clk;
    logic       resetb;
    logic       mon_clk;
    logic       enable;
    logic [2:0] expected_n;
    logic [7:0] meas_period;
    logic [7:0] meas_high;
    logic       meas_valid;
    logic       meas_ack;
    logic       mismatch;
    logic       stuck;
    logic       bypass;

    typedef struct {
        string tag;
        int    plo, phi, hlo, hhi, mm;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   div       = 0;   // 0: mon_clk driven by pulse_len instead
    int   pulse_len = 0;

    clock_div_monitor #(.SIZE(3), .CNT_W(8), .TIMEOUT(64)) dut (
        .clk         (clk),
        .resetb      (resetb),
        .mon_clk     (mon_clk),
        .enable      (enable),
        .expected_n  (expected_n),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .meas_valid  (meas_valid),
        .meas_ack    (meas_ack),
        .mismatch    (mismatch),
        .stuck       (stuck),
        .bypass      (bypass)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divider model: high for div/2 cycles, low for the rest
    initial begin
        int gcnt;
        int last;
        gcnt    = 0;
        last    = 0;
        mon_clk = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (div == 0) begin
                mon_clk = (pulse_len > 0);
                if (pulse_len > 0) pulse_len--;
                gcnt = 0;
            end else begin
                if (div != last || gcnt >= div - 1) gcnt = 0;
                else gcnt++;
                mon_clk = (gcnt < div / 2);
            end
            last = div;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int clip(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic push(input string tag, input int plo, input int phi,
                        input int hlo, input int hhi, input int mm);
        exp_t e;
        e.tag = tag; e.plo = plo; e.phi = phi; e.hlo = hlo; e.hhi = hhi; e.mm = mm;
        sb.push_back(e);
    endtask

    // Wait for a result, pop the scoreboard, check hold stability, optionally ack
    task automatic wait_res(input bit do_ack);
        exp_t e;
        int   got;
        int   p0;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = meas_valid;
        end
        e = sb.pop_front();
        chk({e.tag, "_vld"}, got, 1);
        if (got) begin
            chk({e.tag, "_per"}, meas_period, clip(meas_period, e.plo, e.phi));
            chk({e.tag, "_high"}, meas_high, clip(meas_high, e.hlo, e.hhi));
            chk({e.tag, "_mm"}, mismatch, e.mm);
            chk({e.tag, "_stk"}, stuck, 0);
            p0 = meas_period;
            repeat (3) @(negedge clk);
            chk({e.tag, "_hold_vld"}, meas_valid, 1);
            chk({e.tag, "_hold_per"}, meas_period, p0);
            if (do_ack) begin
                meas_ack = 1'b1;
                @(negedge clk);
                meas_ack = 1'b0;
                chk({e.tag, "_ack_drop"}, meas_valid, 0);
            end
        end
    endtask

    task automatic run_meas(input string tag, input int n, input int d,
                            input int plo, input int phi, input int hlo,
                            input int hhi, input int mm, input bit do_ack);
        @(negedge clk);
        enable     = 1'b0;
        expected_n = 3'(n);
        div        = d;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        push(tag, plo, phi, hlo, hhi, mm);
        wait_res(do_ack);
    endtask

    task automatic chk_clear(input string tag);
        chk({tag, "_vld"},  meas_valid,  0);
        chk({tag, "_per"},  meas_period, 0);
        chk({tag, "_high"}, meas_high,   0);
        chk({tag, "_mm"},   mismatch,    0);
        chk({tag, "_stk"},  stuck,       0);
        chk({tag, "_byp"},  bypass,      0);
    endtask

    initial begin
        int seen;
        resetb     = 1'b0;
        enable     = 1'b0;
        expected_n = 3'd2;
        meas_ack   = 1'b0;
        repeat (3) @(negedge clk);
        chk_clear("rst");
        resetb = 1'b1;

        run_meas("div2", 2, 2, 2, 2, 1, 1, 0, 1'b1);
        run_meas("div5", 5, 5, 4, 6, 2, 3, 0, 1'b1);
        run_meas("div6", 3, 6, 6, 6, 3, 3, 1, 1'b1);

        // Asynchronous reset while a new measurement is under way
        repeat (4) @(negedge clk);
        #2 resetb = 1'b0;
        #1 chk_clear("arst");
        @(negedge clk);
        resetb = 1'b1;

        // Enable dropped while holding a result
        run_meas("div4", 4, 4, 4, 4, 2, 2, 0, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        chk_clear("endis");

        // Unresolvable ratio, then a usable one
        expected_n = 3'd1;
        div        = 4;
        enable     = 1'b1;
        @(negedge clk);
        chk("byp_set", bypass, 1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            seen |= int'(meas_valid);
        end
        chk("byp_novld", seen, 0);
        expected_n = 3'd4;
        push("byp4", 4, 4, 2, 2, 0);
        @(negedge clk);
        chk("byp_clr", bypass, 0);
        wait_res(1'b1);

        // Stall: single pulse, then mon_clk low
        enable = 1'b0;
        div    = 0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        pulse_len = 2;
        @(posedge clk);
        repeat (67) @(posedge clk);
        @(negedge clk);
        chk("stk_pre", stuck, 0);
        @(negedge clk);
        chk("stk_set", stuck, 1);
        chk("stk_novld", meas_valid, 0);
        pulse_len = 2;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stk_still", stuck, 1);
        @(negedge clk);
        chk("stk_clr", stuck, 0);

        // Edge landing on the timeout terminal count closes the period
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        pulse_len = 2;
        @(posedge clk);
        repeat (63) @(posedge clk);
        @(negedge clk);
        pulse_len = 2;
        push("tcnt", 64, 64, 2, 2, 1);
        wait_res(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
